// File: rtl/cache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped write-through cache.
package cache_pkg;

   localparam int unsigned ADDR_W_DEF     = 16;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned INDEX_BITS_DEF = 4;
   localparam int unsigned CNT_W          = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      RESP    = 3'd4
   } state_e;

endpackage

// File: rtl/cache_if.sv
// CPU-side and memory-side bus of the cache; master = requester/memory, slave = cache.
interface cache_if #(
   parameter int unsigned ADDR_W = cache_pkg::ADDR_W_DEF,
   parameter int unsigned DATA_W = cache_pkg::DATA_W_DEF
);
   logic                       cpu_req;
   logic                       cpu_we;
   logic [ADDR_W-1:0]          cpu_addr;
   logic [DATA_W-1:0]          cpu_wdata;
   logic                       cpu_busy;
   logic                       cpu_ready;
   logic [DATA_W-1:0]          cpu_rdata;
   logic                       cpu_hit;
   logic                       mem_rd_en;
   logic                       mem_wr_en;
   logic [ADDR_W-1:0]          mem_addr;
   logic [DATA_W-1:0]          mem_wdata;
   logic [DATA_W-1:0]          mem_rdata;
   logic [cache_pkg::CNT_W-1:0] hit_count;
   logic [cache_pkg::CNT_W-1:0] miss_count;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  cpu_busy, cpu_ready, cpu_rdata, cpu_hit,
      input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata, hit_count, miss_count
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output cpu_busy, cpu_ready, cpu_rdata, cpu_hit,
      output mem_rd_en, mem_wr_en, mem_addr, mem_wdata, hit_count, miss_count
   );
endinterface

// File: rtl/cache_array.sv
// Tag/valid/data storage: combinational lookup, synchronous single write port.
module cache_array #(
   parameter int unsigned INDEX_BITS = 4,
   parameter int unsigned TAG_W      = 12,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INDEX_BITS-1:0] rd_index,
   input  logic [TAG_W-1:0]      rd_tag,
   output logic                  hit_c,
   output logic [DATA_W-1:0]     data_c,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [DATA_W-1:0]     wr_data
);
   localparam int unsigned LINES = 2 ** INDEX_BITS;

   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [DATA_W-1:0] data_q [LINES];

   // Only the valid bits are reset; tag and data contents survive reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (we) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

   assign hit_c  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
   assign data_c = data_q[rd_index];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-line, write-through, no-write-allocate cache controller.
module cache_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
   input  logic    clk,
   input  logic    rst_n,
   cache_if.slave  bus
);
   localparam int unsigned TAG_W = ADDR_W - INDEX_BITS;

   state_e             state_q;
   state_e             state_nxt;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               busy_q;
   logic               ready_q;
   logic               hit_q;
   logic               rd_en_q;
   logic               wr_en_q;
   logic [CNT_W-1:0]   hits_q;
   logic [CNT_W-1:0]   misses_q;
   logic               lk_hit_c;
   logic [DATA_W-1:0]  lk_data_c;
   logic               arr_we_c;
   logic [DATA_W-1:0]  arr_wdata_c;
   logic               accept_c;

   assign accept_c = (state_q == IDLE) && bus.cpu_req;

   cache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W),
      .DATA_W     (DATA_W)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_index (bus.cpu_addr[INDEX_BITS-1:0]),
      .rd_tag   (bus.cpu_addr[ADDR_W-1:INDEX_BITS]),
      .hit_c    (lk_hit_c),
      .data_c   (lk_data_c),
      .we       (arr_we_c),
      .wr_index (addr_q[INDEX_BITS-1:0]),
      .wr_tag   (addr_q[ADDR_W-1:INDEX_BITS]),
      .wr_data  (arr_wdata_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // Next state plus array write strobe (line fill or write-hit update).
   always_comb begin
      state_nxt   = state_q;
      arr_we_c    = 1'b0;
      arr_wdata_c = wdata_q;
      case (state_q)
         IDLE: begin
            if (bus.cpu_req) begin
               if (bus.cpu_we)    state_nxt = WR_REQ;
               else if (lk_hit_c) state_nxt = RESP;
               else               state_nxt = RD_REQ;
            end
         end
         RD_REQ:  state_nxt = RD_WAIT;
         RD_WAIT: begin
            state_nxt   = RESP;
            arr_we_c    = 1'b1;
            arr_wdata_c = bus.mem_rdata;
         end
         WR_REQ: begin
            state_nxt = RESP;
            arr_we_c  = hit_q;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status and strobes registered from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
      end else begin
         busy_q  <= (state_nxt != IDLE);
         ready_q <= (state_nxt == RESP);
         rd_en_q <= (state_nxt == RD_REQ);
         wr_en_q <= (state_nxt == WR_REQ);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         hit_q    <= 1'b0;
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         if (accept_c) begin
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            hit_q   <= lk_hit_c;
            if (!bus.cpu_we) begin
               if (lk_hit_c) begin
                  rdata_q <= lk_data_c;
                  hits_q  <= hits_q + CNT_W'(1);
               end else begin
                  misses_q <= misses_q + CNT_W'(1);
               end
            end
         end
         if (state_q == RD_WAIT) rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.cpu_busy   = busy_q;
   assign bus.cpu_ready  = ready_q;
   assign bus.cpu_rdata  = rdata_q;
   assign bus.cpu_hit    = hit_q;
   assign bus.mem_rd_en  = rd_en_q;
   assign bus.mem_wr_en  = wr_en_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.hit_count  = hits_q;
   assign bus.miss_count = misses_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: 1-cycle memory, directed scenarios, then random traffic vs. a reference model.
module tb_cache_ctrl;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cache_if bus ();

   cache_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory model seen by the DUT
   logic [31:0] mem [int];
   int          rd_pulses = 0;
   int          wr_pulses = 0;
   int          both_seen = 0;
   logic [15:0] last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;

   function automatic logic [31:0] def_word(input int a);
      return (32'(a) * 32'h0000_9E37) ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_rd_en && bus.mem_wr_en) both_seen++;
      if (bus.mem_wr_en) begin
         mem[int'(bus.mem_addr)] = bus.mem_wdata;
         last_wr_addr = bus.mem_addr;
         last_wr_data = bus.mem_wdata;
         wr_pulses++;
      end
      if (bus.mem_rd_en) begin
         bus.mem_rdata <= mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)]
                                                        : def_word(int'(bus.mem_addr));
         rd_pulses++;
      end
   end

   // Reference model: what memory should hold, plus which address each line caches
   logic [31:0] ref_mem [int];
   bit          mv [16];
   int          mt [16];
   logic [15:0] exp_hits;
   logic [15:0] exp_misses;
   logic [31:0] last_rd;

   function automatic logic [31:0] ref_read(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
      exp_hits   = '0;
      exp_misses = '0;
      last_rd    = '0;
   endtask

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One CPU transaction; 'extra' pulses cpu_req again while the cache is busy.
   task automatic do_txn(input bit we, input logic [15:0] a, input logic [31:0] d, input bit extra);
      int  ai;
      int  idx;
      int  tg;
      bit  hit;
      int  lat;
      int  exp_lat;
      int  rd0;
      int  wr0;
      ai  = int'(a);
      idx = ai % 16;
      tg  = ai / 16;
      hit = mv[idx] && (mt[idx] == tg);

      @(negedge clk);
      check("idle_before_req", 64'(bus.cpu_busy), 64'(0));
      rd0 = rd_pulses;
      wr0 = wr_pulses;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;

      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         if (bus.cpu_ready) begin
            lat = k;
            break;
         end
         if (extra && k == 1) begin
            bus.cpu_req  = 1'b1;
            bus.cpu_we   = ~we;
            bus.cpu_addr = a ^ 16'h00F0;
         end else begin
            bus.cpu_req = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.cpu_req = 1'b0;

      if (we) begin
         ref_mem[ai] = d;
      end else begin
         if (hit) exp_hits++;
         else begin
            exp_misses++;
            mv[idx] = 1'b1;
            mt[idx] = tg;
         end
         last_rd = ref_read(ai);
      end
      exp_lat = we ? 2 : (hit ? 1 : 3);

      check("latency", 64'(lat), 64'(exp_lat));
      check("cpu_hit", 64'(bus.cpu_hit), 64'(hit));
      check("cpu_rdata", 64'(bus.cpu_rdata), 64'(last_rd));
      check("hit_count", 64'(bus.hit_count), 64'(exp_hits));
      check("miss_count", 64'(bus.miss_count), 64'(exp_misses));

      @(posedge clk); #1;
      check("ready_one_cycle", 64'(bus.cpu_ready), 64'(0));
      check("busy_after_resp", 64'(bus.cpu_busy), 64'(0));
      check("mem_rd_pulses", 64'(rd_pulses - rd0), 64'((!we && !hit) ? 1 : 0));
      check("mem_wr_pulses", 64'(wr_pulses - wr0), 64'(we ? 1 : 0));
      if (we) begin
         check("mem_wr_addr", 64'(last_wr_addr), 64'(a));
         check("mem_wr_data", 64'(last_wr_data), 64'(d));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},    64'(bus.cpu_busy),   64'(0));
      check({tag, "_ready"},   64'(bus.cpu_ready),  64'(0));
      check({tag, "_hit"},     64'(bus.cpu_hit),    64'(0));
      check({tag, "_rd_en"},   64'(bus.mem_rd_en),  64'(0));
      check({tag, "_wr_en"},   64'(bus.mem_wr_en),  64'(0));
      check({tag, "_rdata"},   64'(bus.cpu_rdata),  64'(0));
      check({tag, "_addr"},    64'(bus.mem_addr),   64'(0));
      check({tag, "_wdata"},   64'(bus.mem_wdata),  64'(0));
      check({tag, "_hits"},    64'(bus.hit_count),  64'(0));
      check({tag, "_misses"},  64'(bus.miss_count), 64'(0));
   endtask

   // Start a read miss and pull reset while it waits on memory data.
   task automatic reset_in_rd_wait(input logic [15:0] a);
      @(negedge clk);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = a;
      bus.cpu_wdata = 32'h0;
      @(posedge clk); #1;
      bus.cpu_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("mid_rst_no_ready", 64'(bus.cpu_ready), 64'(0));
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [15:0] ra;
      rst_n         = 1'b0;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      mem[32'h1234]     = 32'h1111_2222;
      ref_mem[32'h1234] = 32'h1111_2222;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      do_txn(1'b0, 16'h1234, 32'h0, 1'b0);
      do_txn(1'b0, 16'h1234, 32'h0, 1'b0);
      do_txn(1'b1, 16'h1234, 32'hDEAD_BEEF, 1'b0);
      do_txn(1'b0, 16'h1234, 32'h0, 1'b0);
      do_txn(1'b1, 16'h0005, 32'hA5A5_A5A5, 1'b0);
      do_txn(1'b0, 16'h0005, 32'h0, 1'b0);
      do_txn(1'b0, 16'h2234, 32'h0, 1'b0);
      do_txn(1'b0, 16'h1234, 32'h0, 1'b0);
      do_txn(1'b0, 16'h3234, 32'h0, 1'b1);
      do_txn(1'b1, 16'h0008, 32'h0BAD_F00D, 1'b1);
      do_txn(1'b0, 16'h1234, 32'h0, 1'b0);

      reset_in_rd_wait(16'h0077);
      do_txn(1'b0, 16'h1234, 32'h0, 1'b0);

      // Random traffic over four tags so lines hit, conflict and get rewritten
      for (int n = 0; n < 400; n++) begin
         ra = {12'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
         do_txn(($urandom % 4) == 0, ra, $urandom, ($urandom % 5) == 0);
      end

      check("strobes_exclusive", 64'(both_seen), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 16, address width; DATA_W, default 32, word width; INDEX_BITS, default 4, line-index width (16 lines); TAG_W = ADDR_W-INDEX_BITS, derived.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cpu_req  in  1  single-cycle request pulse.
- cpu_we  in  1  1=write, 0=read; qualified by cpu_req.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_busy  out  1  transaction in progress.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid with cpu_ready on reads.
- cpu_hit  out  1  lookup result; valid with cpu_ready.
- mem_rd_en  out  1  memory read strobe.
- mem_wr_en  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_rd_en.
- hit_count  out  16  read-hit counter.
- miss_count  out  16  read-miss counter.

Function
REQ-003 SHALL implement a direct-mapped, one-word-per-line, write-through, no-write-allocate cache: index = cpu_addr[INDEX_BITS-1:0]; tag = cpu_addr[ADDR_W-1:INDEX_BITS].
REQ-004 SHALL accept cpu_req only in IDLE with cpu_busy=0, latching cpu_we, cpu_addr and cpu_wdata; cpu_req while cpu_busy=1 SHALL be ignored.
REQ-005 SHALL use FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- IDLE: read hit -> RESP; read miss -> RD_REQ; write -> WR_REQ.
- RD_REQ -> RD_WAIT.
- RD_WAIT -> RESP.
- WR_REQ -> RESP.
- RESP -> IDLE.
REQ-006 SHALL assert cpu_busy in every state except IDLE.
REQ-007 SHALL drive mem_rd_en=1 only in RD_REQ and mem_wr_en=1 only in WR_REQ; the two strobes are never asserted together.
REQ-008 SHALL drive mem_addr with the latched address and mem_wdata with the latched write data in every state.
REQ-009 In RD_WAIT the block SHALL capture mem_rdata into cpu_rdata and fill the indexed line: data, tag, valid=1.
REQ-010 In WR_REQ on a write hit the block SHALL update the line data; on a write miss it SHALL leave the array unchanged.
REQ-011 SHALL assert cpu_ready for exactly the one cycle spent in RESP.
- Latency from the accepting edge: read hit 1 cycle, read miss 3 cycles, write 2 cycles.
REQ-012 On a read hit cpu_rdata SHALL hold the line data; cpu_hit SHALL hold the IDLE lookup result through RESP; cpu_rdata SHALL hold its value until the next read completes.
REQ-013 SHALL increment hit_count on each read hit and miss_count on each read miss, in the accepting cycle, wrapping modulo 2^16; writes are not counted.

Reset
REQ-014 rst_n=0 SHALL asynchronously force: state IDLE; cpu_busy, cpu_ready, cpu_hit, mem_rd_en, mem_wr_en = 0; cpu_rdata, mem_addr, mem_wdata = 0; all valid bits 0; both counters 0.
REQ-015 Tag and data storage SHALL NOT be reset.
REQ-016 Reset mid-transaction SHALL abort it with no cpu_ready pulse and no line fill; completion of an in-flight memory write is not guaranteed.

Structure
REQ-017 A shared package cache_pkg SHALL hold the default widths and the FSM state enumeration.
REQ-018 Tag, valid and data storage SHALL live in one sub-module, cache_array, with a combinational lookup port and a synchronous write port; the FSM, counters and memory drive SHALL stay in cache_ctrl.

Verification
REQ-019 The bench SHALL pair cache_ctrl with a 1-cycle-latency memory model and cover:
- Cold read 0x1234, memory holds 0x11112222 -> mem_rd_en one cycle; cpu_ready 3 cycles after accept; rdata 0x11112222; cpu_hit=0; miss_count=1.
- Repeat read 0x1234 -> no mem_rd_en; cpu_ready next cycle; cpu_hit=1; hit_count=1.
- Write 0x1234 with 0xDEADBEEF, then read 0x1234 -> mem_wr_en one cycle with addr 0x1234; read hits and returns 0xDEADBEEF.
- Write miss 0x0005 with 0xA5A5A5A5, then read 0x0005 -> write goes to memory only; read misses and returns 0xA5A5A5A5.
- Conflict: read 0x2234 after 0x1234 cached (index 4) -> miss and refill; next read 0x1234 -> miss.
- cpu_req pulsed during a miss -> ignored, single cpu_ready; rst_n low in RD_WAIT -> outputs 0, no cpu_ready, next read 0x1234 misses.
